// File: rtl/systolic_array_2x2.sv
// -----------------------------------------------------------------------------
// systolic_array_2x2
//   Output-stationary 2x2 systolic matrix-multiply core, C = A x B, on unsigned
//   DATA_W-bit operands. Matrices are row-major and flattened so that element k
//   sits at [k*DATA_W +: DATA_W], with k = 2*row + col.
//
//   A run starts when start is sampled high in IDLE or DONE. The operands are
//   latched on that edge, then skewed through the PE grid for five RUN steps.
//   The C matrix is written on the following edge. done is a level that stays
//   high until the next start or rst.
//
// Ports
//   clk     in   clock, all state updates on posedge
//   rst     in   synchronous, active-high reset
//   start   in   request; honoured only in IDLE or DONE
//   a_flat  in   A matrix, 4*DATA_W bits
//   b_flat  in   B matrix, 4*DATA_W bits
//   c_flat  out  C matrix, 4*DATA_W bits, registered
//   busy    out  high in RUN and WRITE
//   done    out  high in DONE, c_flat valid
// -----------------------------------------------------------------------------
module systolic_array_2x2 #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 17,
  parameter int SATURATE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DATA_W-1:0]   a_flat,
  input  logic [4*DATA_W-1:0]   b_flat,
  output logic [4*DATA_W-1:0]   c_flat,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} state_t;

  localparam logic [ACC_W-1:0] C_MAX = ACC_W'((1 << DATA_W) - 1);

  state_t              state;
  logic [2:0]          step;

  logic [DATA_W-1:0]   a_op  [4];
  logic [DATA_W-1:0]   b_op  [4];

  // Skew registers: a leaving column 0 to the right, b leaving row 0 downwards.
  logic [DATA_W-1:0]   a_fwd [2];
  logic [DATA_W-1:0]   b_fwd [2];

  logic [ACC_W-1:0]    acc   [2][2];

  logic [DATA_W-1:0]   a_edge [2];
  logic [DATA_W-1:0]   b_edge [2];
  logic [DATA_W-1:0]   a_in   [2][2];
  logic [DATA_W-1:0]   b_in   [2][2];
  logic [2*DATA_W-1:0] prod   [2][2];

  // Boundary feed. Row i of A enters i steps late, column j of B enters j steps
  // late; everything outside that window is zero, so no stale data reaches a PE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    for (int i = 0; i < 2; i++) begin
      a_edge[i] = '0;
      b_edge[i] = '0;
      if (int'(step) == i) begin
        a_edge[i] = a_op[2*i];
        b_edge[i] = b_op[i];
      end else if (int'(step) == i + 1) begin
        a_edge[i] = a_op[2*i + 1];
        b_edge[i] = b_op[2 + i];
      end
    end

    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        a_in[i][j] = (j == 0) ? a_edge[i] : a_fwd[i];
        b_in[i][j] = (i == 0) ? b_edge[j] : b_fwd[j];
        prod[i][j] = a_in[i][j] * b_in[i][j];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of its neighbours (required for the skew chain).
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      step   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      c_flat <= '0;
      for (int k = 0; k < 4; k++) begin
        a_op[k] <= '0;
        b_op[k] <= '0;
      end
      for (int i = 0; i < 2; i++) begin
        a_fwd[i] <= '0;
        b_fwd[i] <= '0;
        for (int j = 0; j < 2; j++) acc[i][j] <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            for (int k = 0; k < 4; k++) begin
              a_op[k] <= a_flat[k*DATA_W +: DATA_W];
              b_op[k] <= b_flat[k*DATA_W +: DATA_W];
            end
            for (int i = 0; i < 2; i++) begin
              a_fwd[i] <= '0;
              b_fwd[i] <= '0;
              for (int j = 0; j < 2; j++) acc[i][j] <= '0;
            end
            step  <= '0;
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end

        RUN: begin
          for (int i = 0; i < 2; i++) begin
            a_fwd[i] <= a_in[i][0];
            b_fwd[i] <= b_in[0][i];
            for (int j = 0; j < 2; j++)
              acc[i][j] <= acc[i][j] + ACC_W'(prod[i][j]);
          end
          // Step 4 is the drain step: all feeds are zero by then.
          if (step == 3'd4) state <= WRITE;
          else              step  <= step + 3'd1;
        end

        WRITE: begin
          for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
              c_flat[(2*i + j)*DATA_W +: DATA_W] <=
                (SATURATE != 0 && acc[i][j] > C_MAX) ? C_MAX[DATA_W-1:0]
                                                     : acc[i][j][DATA_W-1:0];
            end
          end
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_array_2x2.sv
// -----------------------------------------------------------------------------
// tb_systolic_array_2x2
//   Two instances share stimulus: one saturating, one truncating. Expected C is
//   computed with plain matrix arithmetic; timing expectations come from the
//   fixed six-edge latency. Inputs are driven and outputs sampled on negedge.
// -----------------------------------------------------------------------------
module tb_systolic_array_2x2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a_flat, b_flat;
  logic [31:0] c_sat, c_tr;
  logic        busy_sat, busy_tr, done_sat, done_tr;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_sat = '0;
  logic [31:0] exp_tr  = '0;

  always #5 clk = ~clk;

  systolic_array_2x2 #(.DATA_W(8), .ACC_W(17), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .a_flat(a_flat), .b_flat(b_flat),
    .c_flat(c_sat), .busy(busy_sat), .done(done_sat)
  );

  systolic_array_2x2 #(.DATA_W(8), .ACC_W(17), .SATURATE(0)) u_tr (
    .clk(clk), .rst(rst), .start(start), .a_flat(a_flat), .b_flat(b_flat),
    .c_flat(c_tr), .busy(busy_tr), .done(done_tr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int e0, input int e1, input int e2, input int e3);
    logic [31:0] r;
    r = {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    return r;
  endfunction

  // Reference: C[i][j] = sum_m A[i][m]*B[m][j], then clamp or wrap to 8 bits.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input bit sat);
    logic [31:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int m = 0; m < 2; m++)
          s += int'(a[(2*i + m)*8 +: 8]) * int'(b[(2*m + j)*8 +: 8]);
        r[(2*i + j)*8 +: 8] = (sat && s > 255) ? 8'd255 : 8'(s % 256);
      end
    end
    return r;
  endfunction

  task automatic check_all(input string tag, input logic busy_e, input logic done_e);
    check({tag, ".busy_sat"}, {31'd0, busy_sat}, {31'd0, busy_e});
    check({tag, ".done_sat"}, {31'd0, done_sat}, {31'd0, done_e});
    check({tag, ".c_sat"},    c_sat,             exp_sat);
    check({tag, ".busy_tr"},  {31'd0, busy_tr},  {31'd0, busy_e});
    check({tag, ".done_tr"},  {31'd0, done_tr},  {31'd0, done_e});
    check({tag, ".c_tr"},     c_tr,              exp_tr);
  endtask

  // Called at a negedge. Starts a run on the next edge (E). disturb_at / rst_at
  // name the edge offset (E+n) at which start is pulsed with all-ones operands
  // or rst is asserted; 0 means never. Between edges, operands are scrambled.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input int disturb_at, input int rst_at);
    logic [31:0] n_sat, n_tr;
    n_sat  = model(a, b, 1'b1);
    n_tr   = model(a, b, 1'b0);
    a_flat = a;
    b_flat = b;
    start  = 1'b1;
    @(posedge clk);                       // edge E
    for (int t = 0; t <= 5; t++) begin
      @(negedge clk);                     // after edge E+t
      check_all($sformatf("%s.e%0d", name, t), 1'b1, 1'b0);
      start  = 1'b0;
      a_flat = $urandom;
      b_flat = $urandom;
      if (t + 1 == disturb_at) begin
        start  = 1'b1;
        a_flat = 32'h0101_0101;
        b_flat = 32'h0101_0101;
      end
      if (t + 1 == rst_at) rst = 1'b1;
      @(posedge clk);
      if (rst) begin
        @(negedge clk);
        rst     = 1'b0;
        start   = 1'b0;
        exp_sat = '0;
        exp_tr  = '0;
        check_all({name, ".rst"}, 1'b0, 1'b0);
        return;
      end
    end
    @(negedge clk);                       // after edge E+6
    start   = 1'b0;
    exp_sat = n_sat;
    exp_tr  = n_tr;
    check_all({name, ".fin"}, 1'b0, 1'b1);
  endtask

  task automatic idle_cycles(input string name, input int n, input logic done_e);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_all($sformatf("%s.i%0d", name, k), 1'b0, done_e);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    a_flat = '0;
    b_flat = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset", 1'b0, 1'b0);
    rst = 1'b0;

    // start sampled while idle and low: nothing happens
    idle_cycles("idle", 2, 1'b0);

    run_op("ident",  pack(1, 2, 3, 4), pack(1, 0, 0, 1), 0, 0);
    idle_cycles("hold", 2, 1'b1);
    run_op("mul",    pack(1, 2, 3, 4), pack(5, 6, 7, 8), 0, 0);
    run_op("max",    32'hFFFF_FFFF,    32'hFFFF_FFFF,    0, 0);
    run_op("busy_st", pack(10, 0, 0, 10), pack(20, 0, 0, 20), 2, 0);
    run_op("restart", pack(2, 0, 0, 2), pack(3, 3, 3, 3), 0, 0);

    // rst mid-run: outputs back to zero, done never rises for the abandoned run
    run_op("abort",  pack(9, 9, 9, 9), pack(9, 9, 9, 9), 0, 4);
    idle_cycles("post_rst", 3, 1'b0);
    run_op("after",  pack(1, 2, 3, 4), pack(5, 6, 7, 8), 0, 0);

    for (int r = 0; r < 12; r++)
      run_op($sformatf("rnd%0d", r), $urandom, $urandom, int'($urandom_range(0, 5)), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
